// File: rtl/synth_pkg.sv
// Shared constants and types for the synthesizer parameter bank.
// Holds the parameter slot indices, the auto-repeat FSM state type and default bounds.
package synth_pkg;

  localparam int P_OCTAVE    = 0;
  localparam int P_AMPLITUDE = 1;
  localparam int P_ATTACK    = 2;
  localparam int P_DECAY     = 3;
  localparam int P_SUSTAIN   = 4;
  localparam int P_RELEASE   = 5;

  localparam int NUM_PARAMS_DEF = P_RELEASE + 1;
  localparam int MAX_VAL_DEF    = 1 << 30;
  localparam int STEP_DEF       = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } rep_state_t;

endpackage

// File: rtl/key_repeat.sv
// Key auto-repeat: one step on press, another after REPEAT_DELAY cycles, then every
// REPEAT_PERIOD cycles while the same key stays held on the same selection.
module key_repeat
  import synth_pkg::*;
#(
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter int SEL_W         = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             clear,
  input  logic [SEL_W-1:0] sel,
  output logic             step_up,
  output logic             step_down
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW      = $clog2(CNT_MAX + 2);

  rep_state_t       state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             dir_up, dir_up_nxt;
  logic [SEL_W-1:0] sel_q;
  logic             one_req;

  assign one_req = inc ^ dec;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      dir_up <= 1'b0;
      sel_q  <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      dir_up <= dir_up_nxt;
      sel_q  <= sel;
    end
  end

  // The counter is loaded with the full interval and a step fires on the cycle it
  // would reach zero, so the press step and the first repeat are REPEAT_DELAY apart.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    dir_up_nxt = dir_up;
    step_up    = 1'b0;
    step_down  = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (!clear && one_req) begin
          step_up    = inc;
          step_down  = dec;
          dir_up_nxt = inc;
          cnt_nxt    = CW'(REPEAT_DELAY);
          state_nxt  = ST_DELAY;
        end
      end
      ST_DELAY, ST_REPEAT: begin
        if (clear || !one_req || (inc != dir_up) || (sel != sel_q)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt <= CW'(1)) begin
          step_up   = dir_up;
          step_down = !dir_up;
          cnt_nxt   = CW'(REPEAT_PERIOD);
          state_nxt = ST_REPEAT;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/synth_param_bank.sv
// Bank of saturating synthesizer parameters adjusted by held keys with auto-repeat,
// or written directly by a load strobe; all outputs are registered.
module synth_param_bank
  import synth_pkg::*;
#(
  parameter int NUM_PARAMS = NUM_PARAMS_DEF,
  parameter int WIDTH      = 31,
  parameter int STEP       = STEP_DEF,
  parameter int MAX_VAL    = MAX_VAL_DEF,
  parameter logic [NUM_PARAMS*WIDTH-1:0] DEFAULTS = {
    WIDTH'(MAX_VAL_DEF), WIDTH'(MAX_VAL_DEF), WIDTH'(MAX_VAL_DEF),
    WIDTH'(0), WIDTH'(MAX_VAL_DEF), WIDTH'(4)
  },
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  localparam int SEL_W = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SEL_W-1:0]            sel,
  input  logic                        inc,
  input  logic                        dec,
  input  logic                        load,
  input  logic [WIDTH-1:0]            load_value,
  output logic [NUM_PARAMS*WIDTH-1:0] params,
  output logic [WIDTH-1:0]            sel_value,
  output logic                        changed,
  output logic                        at_max,
  output logic                        at_min
);

  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] STEP_V  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] DEF_SEL = DEFAULTS[WIDTH-1:0];

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v > MAX_V - STEP_V) ? MAX_V : v + STEP_V;
  endfunction

  function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
    return (v < STEP_V) ? '0 : v - STEP_V;
  endfunction

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_V) ? MAX_V : v;
  endfunction

  logic [WIDTH-1:0] regs [NUM_PARAMS];
  logic [WIDTH-1:0] nxt  [NUM_PARAMS];
  logic [WIDTH-1:0] sel_nxt;
  logic             sel_ok;
  logic             any_chg;
  logic             step_up, step_down;

  assign sel_ok = (int'(sel) < NUM_PARAMS);

  // Out-of-range selections look like released keys, so the repeater never arms.
  key_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD),
    .SEL_W        (SEL_W)
  ) u_key_repeat (
    .clk      (clk),
    .reset    (reset),
    .inc      (inc & sel_ok),
    .dec      (dec & sel_ok),
    .clear    (load),
    .sel      (sel),
    .step_up  (step_up),
    .step_down(step_down)
  );

  // Next-value stage: load beats any step; only the selected slot may move.
  always_comb begin
    any_chg = 1'b0;
    sel_nxt = '0;
    for (int i = 0; i < NUM_PARAMS; i++) begin
      nxt[i] = regs[i];
      if (sel_ok && (sel == SEL_W'(i))) begin
        if (load)           nxt[i] = clamp_load(load_value);
        else if (step_up)   nxt[i] = sat_inc(regs[i]);
        else if (step_down) nxt[i] = sat_dec(regs[i]);
        sel_nxt = nxt[i];
      end
      if (nxt[i] != regs[i]) any_chg = 1'b1;
    end
  end

  // Register stage: storage and status flags updated together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PARAMS; i++) regs[i] <= DEFAULTS[i*WIDTH +: WIDTH];
      sel_value <= DEF_SEL;
      changed   <= 1'b0;
      at_max    <= (DEF_SEL == MAX_V);
      at_min    <= (DEF_SEL == '0);
    end else begin
      for (int i = 0; i < NUM_PARAMS; i++) regs[i] <= nxt[i];
      sel_value <= sel_nxt;
      changed   <= any_chg;
      at_max    <= sel_ok && (sel_nxt == MAX_V);
      at_min    <= sel_ok && (sel_nxt == '0);
    end
  end

  for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_flat
    assign params[g*WIDTH +: WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_synth_param_bank.sv
// Directed bench for synth_param_bank with a small configuration (8-bit values,
// step 10, ceiling 100, repeat delay 4, repeat period 2, every default 50).
module tb_synth_param_bank;

  logic        clk;
  logic        reset;
  logic [2:0]  sel;
  logic        inc, dec, load;
  logic [7:0]  load_value;
  logic [47:0] params;
  logic [7:0]  sel_value;
  logic        changed, at_max, at_min;

  int n_checks = 0;
  int n_fail   = 0;

  synth_param_bank #(
    .NUM_PARAMS   (6),
    .WIDTH        (8),
    .STEP         (10),
    .MAX_VAL      (100),
    .DEFAULTS     ({6{8'd50}}),
    .REPEAT_DELAY (4),
    .REPEAT_PERIOD(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .inc       (inc),
    .dec       (dec),
    .load      (load),
    .load_value(load_value),
    .params    (params),
    .sel_value (sel_value),
    .changed   (changed),
    .at_max    (at_max),
    .at_min    (at_min)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] p(input int i);
    return params[i*8 +: 8];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; sel = 3'd0; inc = 1'b0; dec = 1'b0; load = 1'b0; load_value = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (p(i) !== 8'd50) begin n_fail++; $display("FAIL reset_param%0d got %0d want 50", i, p(i)); end
    end
    n_checks++;
    if (sel_value !== 8'd50) begin n_fail++; $display("FAIL reset_sel_value got %0d want 50", sel_value); end
    n_checks++;
    if (changed !== 1'b0) begin n_fail++; $display("FAIL reset_changed got %b want 0", changed); end
    n_checks++;
    if ({at_max, at_min} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {at_max, at_min}); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_inc;
    sel = 3'd1; tick();
    inc = 1'b1; tick();
    inc = 1'b0;
    n_checks++;
    if (p(1) !== 8'd60) begin n_fail++; $display("FAIL single_inc_value got %0d want 60", p(1)); end
    n_checks++;
    if (changed !== 1'b1) begin n_fail++; $display("FAIL single_inc_changed got %b want 1", changed); end
    n_checks++;
    if (sel_value !== 8'd60) begin n_fail++; $display("FAIL single_inc_sel_value got %0d want 60", sel_value); end
    n_checks++;
    if ({p(5), p(4), p(3), p(2), p(0)} !== {5{8'd50}}) begin
      n_fail++; $display("FAIL single_inc_others got %h want all 32", {p(5), p(4), p(3), p(2), p(0)});
    end
    tick();
    n_checks++;
    if (changed !== 1'b0 || p(1) !== 8'd60) begin
      n_fail++; $display("FAIL single_inc_release got changed=%b val=%0d want 0/60", changed, p(1));
    end
  endtask

  task automatic test_repeat;
    logic [7:0] exp_v, prev;
    logic       exp_c, stp;
    sel = 3'd2; tick();
    inc = 1'b1;
    exp_v = 8'd50;
    for (int k = 0; k < 14; k++) begin
      stp   = (k == 0) || (k >= 4 && (k % 2) == 0);
      prev  = exp_v;
      if (stp) exp_v = (exp_v > 8'd90) ? 8'd100 : exp_v + 8'd10;
      exp_c = (exp_v != prev);
      tick();
      n_checks++;
      if (p(2) !== exp_v) begin n_fail++; $display("FAIL repeat_value k=%0d got %0d want %0d", k, p(2), exp_v); end
      n_checks++;
      if (changed !== exp_c) begin n_fail++; $display("FAIL repeat_changed k=%0d got %b want %b", k, changed, exp_c); end
    end
    n_checks++;
    if (at_max !== 1'b1) begin n_fail++; $display("FAIL repeat_at_max got %b want 1", at_max); end
    inc = 1'b0; tick();
  endtask

  task automatic test_both_and_dec;
    sel = 3'd3; tick();
    inc = 1'b1; dec = 1'b1; tick();
    n_checks++;
    if (p(3) !== 8'd50 || changed !== 1'b0) begin
      n_fail++; $display("FAIL both_keys got val=%0d changed=%b want 50/0", p(3), changed);
    end
    inc = 1'b0; dec = 1'b0;
    load = 1'b1; load_value = 8'd5; tick();
    load = 1'b0;
    n_checks++;
    if (p(3) !== 8'd5) begin n_fail++; $display("FAIL load5 got %0d want 5", p(3)); end
    dec = 1'b1; tick();
    dec = 1'b0;
    n_checks++;
    if (p(3) !== 8'd0 || changed !== 1'b1) begin
      n_fail++; $display("FAIL dec_floor got val=%0d changed=%b want 0/1", p(3), changed);
    end
    n_checks++;
    if (at_min !== 1'b1) begin n_fail++; $display("FAIL dec_at_min got %b want 1", at_min); end
    tick();
    dec = 1'b1; tick();
    dec = 1'b0;
    n_checks++;
    if (p(3) !== 8'd0 || changed !== 1'b0) begin
      n_fail++; $display("FAIL dec_saturated got val=%0d changed=%b want 0/0", p(3), changed);
    end
    tick();
  endtask

  task automatic test_load_priority;
    sel = 3'd0; tick();
    load = 1'b1; load_value = 8'd200; inc = 1'b1; tick();
    load = 1'b0; inc = 1'b0;
    n_checks++;
    if (p(0) !== 8'd100) begin n_fail++; $display("FAIL load_clamp got %0d want 100", p(0)); end
    n_checks++;
    if (at_max !== 1'b1 || changed !== 1'b1) begin
      n_fail++; $display("FAIL load_flags got at_max=%b changed=%b want 1/1", at_max, changed);
    end
    tick();
    n_checks++;
    if (p(0) !== 8'd100 || changed !== 1'b0) begin
      n_fail++; $display("FAIL load_after got val=%0d changed=%b want 100/0", p(0), changed);
    end
  endtask

  task automatic test_reset_mid_repeat;
    logic [7:0] exp_v;
    sel = 3'd4; tick();
    inc = 1'b1;
    repeat (7) tick();
    n_checks++;
    if (p(4) !== 8'd80) begin n_fail++; $display("FAIL pre_reset_repeat got %0d want 80", p(4)); end
    #3;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (p(i) !== 8'd50) begin n_fail++; $display("FAIL async_reset_param%0d got %0d want 50", i, p(i)); end
    end
    n_checks++;
    if (sel_value !== 8'd50 || changed !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_outputs got sel_value=%0d changed=%b want 50/0", sel_value, changed);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      exp_v = (k < 4) ? 8'd60 : 8'd70;
      n_checks++;
      if (p(4) !== exp_v) begin n_fail++; $display("FAIL post_reset k=%0d got %0d want %0d", k, p(4), exp_v); end
    end
    inc = 1'b0; tick();
  endtask

  task automatic test_bad_sel;
    sel = 3'd7; inc = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (params !== {8'd50, 8'd70, 8'd50, 8'd50, 8'd50, 8'd50}) begin
      n_fail++; $display("FAIL bad_sel_inc got %h want 324632323232", params);
    end
    n_checks++;
    if (sel_value !== 8'd0) begin n_fail++; $display("FAIL bad_sel_value got %0d want 0", sel_value); end
    n_checks++;
    if ({at_max, at_min, changed} !== 3'b000) begin
      n_fail++; $display("FAIL bad_sel_flags got %b want 000", {at_max, at_min, changed});
    end
    inc = 1'b0; load = 1'b1; load_value = 8'd20; tick();
    load = 1'b0;
    n_checks++;
    if (params !== {8'd50, 8'd70, 8'd50, 8'd50, 8'd50, 8'd50}) begin
      n_fail++; $display("FAIL bad_sel_load got %h want 324632323232", params);
    end
  endtask

  task automatic test_sel_change;
    sel = 3'd1; tick();
    inc = 1'b1; tick();
    n_checks++;
    if (p(1) !== 8'd60) begin n_fail++; $display("FAIL selchg_first got %0d want 60", p(1)); end
    tick();
    sel = 3'd2; tick();
    n_checks++;
    if (p(2) !== 8'd50 || p(1) !== 8'd60 || changed !== 1'b0) begin
      n_fail++; $display("FAIL selchg_abort got p2=%0d p1=%0d changed=%b want 50/60/0", p(2), p(1), changed);
    end
    tick();
    n_checks++;
    if (p(2) !== 8'd60 || changed !== 1'b1) begin
      n_fail++; $display("FAIL selchg_fresh got p2=%0d changed=%b want 60/1", p(2), changed);
    end
    inc = 1'b0; tick();
  endtask

  initial begin
    test_reset();
    test_single_inc();
    test_repeat();
    test_both_and_dec();
    test_load_priority();
    test_reset_mid_repeat();
    test_bad_sel();
    test_sel_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no completion want finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/synth_param_bank.md
SYNTH_PARAM_BANK -- requirements
Module: synth_param_bank

Interface
REQ-001 Parameter NUM_PARAMS, default 6, meaning: count of stored parameters (octave, amplitude, attack, decay, sustain, release).
REQ-002 Parameter WIDTH, default 31, meaning: bits per parameter.
REQ-003 Parameter STEP, default 10, meaning: increment/decrement amount per step.
REQ-004 Parameter MAX_VAL, default 2^30, meaning: upper saturation bound; lower bound is 0.
REQ-005 Parameter DEFAULTS, default {2^30,2^30,2^30,0,2^30,4}, meaning: flattened NUM_PARAMS*WIDTH reset values, index 0 in LSBs.
REQ-006 Parameters REPEAT_DELAY, default 25_000_000, and REPEAT_PERIOD, default 5_000_000, meaning: cycles before first auto-repeat and between repeats.
REQ-007 clk  in  1  system clock, single clock domain.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 sel  in  clog2(NUM_PARAMS)  selected parameter index.
REQ-010 inc / dec  in  1 each  level "key held" requests.
REQ-011 load  in  1  one-cycle strobe writing load_value into selected parameter.
REQ-012 load_value  in  WIDTH  absolute value for load.
REQ-013 params  out  NUM_PARAMS*WIDTH  all parameter values, registered.
REQ-014 sel_value  out  WIDTH  registered value of selected parameter.
REQ-015 changed  out  1  one-cycle pulse when any stored value actually changes.
REQ-016 at_max / at_min  out  1 each  selected parameter equals MAX_VAL / 0.

Function
REQ-017 Stepping FSM SHALL have states IDLE, DELAY, REPEAT.
REQ-018 IDLE: exactly one of inc/dec high -> apply one step to params[sel] same edge, load counter with REPEAT_DELAY, go DELAY.
REQ-019 DELAY: request still held and counter reaches 0 -> apply one step, load REPEAT_PERIOD, go REPEAT.
REQ-020 REPEAT: request held and counter reaches 0 -> apply one step, reload REPEAT_PERIOD, stay.
REQ-021 Request released, both inc and dec high, direction reversed, or sel changed -> go IDLE with no step that cycle; new step requires fresh press from IDLE.
REQ-022 Increment SHALL saturate: value > MAX_VAL-STEP -> MAX_VAL; decrement: value < STEP -> 0; no wrap-around.
REQ-023 load SHALL take priority over any step in the same cycle, clamp load_value to MAX_VAL, and force FSM to IDLE.
REQ-024 sel >= NUM_PARAMS SHALL suppress steps and loads; sel_value reads 0, at_max/at_min 0.
REQ-025 Register update latency 1 cycle: params, sel_value, changed valid edge after request sampled.
REQ-026 changed SHALL stay 0 when a step or load leaves the value unchanged (saturated or equal).
REQ-027 Non-selected parameters SHALL never change except by reset.

Reset
REQ-028 reset low SHALL asynchronously set params to DEFAULTS, FSM to IDLE, counter to 0, changed to 0, sel_value to DEFAULTS[0] slice.
REQ-029 Reset asserted mid-repeat SHALL abort repeat; after release, held inc SHALL be treated as fresh press.

Structure
REQ-030 Shared package synth_pkg SHALL hold parameter index constants (P_OCTAVE=0 .. P_RELEASE=5), the FSM state typedef, and default MAX_VAL/STEP constants.
REQ-031 One sub-module, key_repeat (FSM plus counter, emits step_up/step_down pulses), SHALL be instantiated; saturation and storage remain in synth_param_bank.

Verification (WIDTH=8, NUM_PARAMS=6, STEP=10, MAX_VAL=100, REPEAT_DELAY=4, REPEAT_PERIOD=2, DEFAULTS all 50)
REQ-032 sel=1, inc high 1 cycle -> params[1]=60 next edge, changed pulses once, others remain 50.
REQ-033 sel=2, inc held 10 cycles -> steps at cycles 0,4,6,8 -> params[2]=90; held further -> saturates 100, at_max=1, changed stays 0 after saturation.
REQ-034 sel=3, inc and dec both high -> no change, changed=0; dec alone from value 5 (after load 5) -> 0, at_min=1.
REQ-035 sel=0, load=1 load_value=200 with inc high same cycle -> params[0]=100, no step applied.
REQ-036 inc held in REPEAT, reset pulsed low mid-cycle -> all params 50 immediately; after reset release with inc held -> one step to 60, next at +4 cycles.
REQ-037 sel=7 with inc held -> no parameter changes, sel_value=0.
